uart_baud_gen: RTL

Parametrised UART bit-timing generator: one free-running TX bit-boundary tick, one RX bit-centre tick that can be re-phased on a detected start-bit edge, and an oversample tick for RX edge detection/filtering. The divisor is runtime-programmable and defaults to 9600 baud from a 49.152 MHz clock. It sits between the clock domain and the UART TX/RX framers and replaces fixed-rate, fixed-phase bps generators.

---
 rtl/uart_baud_gen_if.sv | 28 ++
 rtl/uart_baud_gen.sv | 92 +++++++++
 2 files changed

// File: rtl/uart_baud_gen_if.sv
// Control/status bundle between the UART framers and the bit-timing generator.
// Latency: none, plain wires.
// Backpressure: none; ticks are pulses, requests are single-cycle strobes.
interface uart_baud_gen_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             div_wr;
    logic [DIV_W-1:0] div_in;
    logic             rx_align;
    logic             tx_tick;
    logic             rx_mid;
    logic             ovs_tick;
    logic [DIV_W-1:0] div_cur;
    logic             div_err;

    // framer / CSR side
    modport master (
        output en, div_wr, div_in, rx_align,
        input  tx_tick, rx_mid, ovs_tick, div_cur, div_err
    );

    // baud generator side
    modport slave (
        input  en, div_wr, div_in, rx_align,
        output tx_tick, rx_mid, ovs_tick, div_cur, div_err
    );
endinterface

// File: rtl/uart_baud_gen.sv
// UART bit timing: TX bit-boundary tick, re-phasable RX bit-centre tick, oversample tick.
// Latency: ticks decode counter state; div_wr / rx_align / en act on the next clk edge.
// Backpressure: none; ticks free-run and a div_wr strobe is accepted every cycle.
module uart_baud_gen #(
    parameter int CLK_HZ = 49152000,
    parameter int BAUD   = 9600,
    parameter int DIV_W  = 16,
    parameter int OVS    = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_baud_gen_if.slave bus
);
    localparam int               OVS_SH      = $clog2(OVS);
    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_HZ / BAUD);
    // Smallest divisor that keeps ovs_div >= 2 and half >= OVS.
    localparam logic [DIV_W-1:0] MIN_DIV     = DIV_W'(2 * OVS);
    localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] tx_cnt;
    logic [DIV_W-1:0] rx_cnt;
    logic [DIV_W-1:0] ovs_cnt;
    logic             err_q;

    logic [DIV_W-1:0] ovs_div;
    logic [DIV_W-1:0] half;
    logic             tx_term;
    logic             rx_term;
    logic             ovs_term;
    logic             div_ok;

    // Terminal-count decodes shared by the wrap logic and the tick outputs.
    always_comb begin
        ovs_div  = div_q >> OVS_SH;
        half     = div_q >> 1;
        tx_term  = (tx_cnt == div_q - ONE);
        rx_term  = (rx_cnt == div_q - ONE);
        ovs_term = (ovs_cnt == ovs_div - ONE);
        div_ok   = (bus.div_in >= MIN_DIV);
    end

    // Divisor register and sticky reject flag; a rejected write leaves the rate alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
            err_q <= 1'b0;
        end else if (bus.div_wr) begin
            if (div_ok) begin
                div_q <= bus.div_in;
                err_q <= 1'b0;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    // Bit-phase counters: divisor load restarts all, en low clears all, rx_align re-phases RX only.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            ovs_cnt <= '0;
        end else if (bus.div_wr) begin
            // A rejected divisor freezes the counters for this cycle.
            if (div_ok) begin
                tx_cnt  <= '0;
                rx_cnt  <= '0;
                ovs_cnt <= '0;
            end
        end else if (!bus.en) begin
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            ovs_cnt <= '0;
        end else begin
            tx_cnt <= tx_term ? '0 : tx_cnt + ONE;
            if (bus.rx_align) begin
                rx_cnt  <= '0;
                ovs_cnt <= '0;
            end else begin
                rx_cnt  <= rx_term  ? '0 : rx_cnt + ONE;
                ovs_cnt <= ovs_term ? '0 : ovs_cnt + ONE;
            end
        end
    end

    assign bus.tx_tick  = bus.en & tx_term;
    assign bus.rx_mid   = bus.en & (rx_cnt == half);
    assign bus.ovs_tick = bus.en & ovs_term;
    assign bus.div_cur  = div_q;
    assign bus.div_err  = err_q;
endmodule
